// File: rtl/onn_pkg.sv
// ----------------------------------------------------------------------------
// onn_pkg
// Shared definitions for the ONN run controller: network geometry, phase
// vector types, the controller state encoding and a helper that extracts one
// neuron's phase from a packed phase vector.
// Optional feature macro used by the design: ONN_TOL_EN (tolerant compare).
// ----------------------------------------------------------------------------
package onn_pkg;

    localparam int N_NEURONS = 4;
    localparam int PHASE_W   = 16;
    localparam int VEC_W     = N_NEURONS * PHASE_W;

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [VEC_W-1:0]   phase_vec_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } onn_state_e;

    // Neuron idx occupies bits [idx*PHASE_W +: PHASE_W] of a phase vector.
    function automatic phase_t phase_slice(input phase_vec_t vec, input int idx);
        return vec[idx*PHASE_W +: PHASE_W];
    endfunction

endpackage

// File: rtl/onn_run_controller_if.sv
// ----------------------------------------------------------------------------
// onn_run_controller_if
// Groups the host-side and network-side signals of the run controller.
//   slave  : controller view (drives phi_in, net_init, full_tick, status)
//   master : host/network view (drives start, abort, pattern_in, phi_out)
// Signals:
//   start       1-cycle run request, honoured only in IDLE or DONE
//   abort       ends an active run; wins over start in the same cycle
//   pattern_in  initial phases, captured when start is honoured
//   phi_out     phases reported by the network
//   phi_in      latched start pattern driven to the network
//   net_init    active-high network init
//   full_tick   1-cycle network tick
//   busy        high in INIT, RUN, CHECK
//   done        1-cycle pulse when a run ends
//   converged   run outcome, meaningful while in DONE
//   tick_count  ticks issued in the current run
//   result      last sampled phase vector
//   state_dbg   controller state for observation
// Control is pulse based (no valid/ready pairs): a run request is a single
// cycle of start; completion is the single-cycle done pulse, after which
// converged/result/tick_count hold until the next accepted start.
// ----------------------------------------------------------------------------
interface onn_run_controller_if #(
    parameter int MAX_TICKS = 1024
) ();
    import onn_pkg::*;

    localparam int TC_W = $clog2(MAX_TICKS + 1);

    logic              start;
    logic              abort;
    phase_vec_t        pattern_in;
    phase_vec_t        phi_out;
    phase_vec_t        phi_in;
    logic              net_init;
    logic              full_tick;
    logic              busy;
    logic              done;
    logic              converged;
    logic [TC_W-1:0]   tick_count;
    phase_vec_t        result;
    onn_state_e        state_dbg;

    modport slave (
        input  start, abort, pattern_in, phi_out,
        output phi_in, net_init, full_tick, busy, done, converged,
               tick_count, result, state_dbg
    );

    modport master (
        output start, abort, pattern_in, phi_out,
        input  phi_in, net_init, full_tick, busy, done, converged,
               tick_count, result, state_dbg
    );

endinterface

// File: rtl/onn_phase_cmp.sv
// ----------------------------------------------------------------------------
// onn_phase_cmp
// Combinational N-way comparison of two phase vectors.
//   a_i     : current phase vector
//   b_i     : previous phase vector
//   match_o : 1 when every neuron of a_i matches the same neuron of b_i
// Default build: exact equality per neuron.
// With ONN_TOL_EN defined: a neuron matches when its circular distance
// min(d, 2^PHASE_W - d), d = a - b mod 2^PHASE_W, is at most TOL.
// ----------------------------------------------------------------------------
module onn_phase_cmp
    import onn_pkg::*;
#(
`ifdef ONN_TOL_EN
    parameter int TOL = 2
`endif
) (
    input  phase_vec_t a_i,
    input  phase_vec_t b_i,
    output logic       match_o
);

`ifdef ONN_TOL_EN
    localparam phase_t TOL_P = phase_t'(TOL);

    phase_t diff_fwd;
    phase_t diff_bwd;

    always_comb begin
        match_o  = 1'b1;
        diff_fwd = '0;
        diff_bwd = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            // Modular subtraction in both directions; the smaller one is the
            // circular distance, so it is within TOL iff either one is.
            diff_fwd = phase_slice(a_i, i) - phase_slice(b_i, i);
            diff_bwd = phase_slice(b_i, i) - phase_slice(a_i, i);
            if ((diff_fwd > TOL_P) && (diff_bwd > TOL_P)) begin
                match_o = 1'b0;
            end
        end
    end
`else
    always_comb begin
        match_o = 1'b1;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (phase_slice(a_i, i) != phase_slice(b_i, i)) begin
                match_o = 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/onn_run_controller.sv
// ----------------------------------------------------------------------------
// onn_run_controller
// Sequences one recall run of the oscillatory neuron network: latches a start
// pattern, holds the network in init, issues full_tick pulses every TICK_DIV
// clocks, samples phi_out three clocks after each tick and ends the run on
// convergence (STABLE_TICKS consecutive matching samples), timeout
// (MAX_TICKS ticks) or abort.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    onn_run_controller_if.slave (host and network signals)
// Optional feature macro: ONN_TOL_EN enables tolerant phase comparison
// (parameter TOL); without it samples must match exactly.
// ----------------------------------------------------------------------------
module onn_run_controller
    import onn_pkg::*;
#(
    parameter int TICK_DIV     = 16,
    parameter int INIT_CYCLES  = 8,
    parameter int MAX_TICKS    = 1024,
    parameter int STABLE_TICKS = 3
`ifdef ONN_TOL_EN
    ,
    parameter int TOL          = 2
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    onn_run_controller_if.slave  bus
);

    localparam int TC_W    = $clog2(MAX_TICKS + 1);
    localparam int ST_W    = $clog2(STABLE_TICKS + 1);
    localparam int CNT_MAX = (TICK_DIV > INIT_CYCLES) ? TICK_DIV : INIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Period position at which CHECK samples: two settle clocks after the tick.
    localparam int SAMPLE_POS = 2;

    onn_state_e        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    phase_vec_t        phi_in_q,    phi_in_d;
    phase_vec_t        prev_q,      prev_d;
    phase_vec_t        result_q,    result_d;
    logic              have_prev_q, have_prev_d;
    logic [ST_W-1:0]   stable_q,    stable_d;
    logic [TC_W-1:0]   tick_q,      tick_d;
    logic              converged_q, converged_d;
    logic              done_q,      done_d;

    logic              full_tick;
    logic              start_ok;
    logic              cmp_match;

    onn_phase_cmp
`ifdef ONN_TOL_EN
        #(.TOL(TOL))
`endif
    u_cmp (
        .a_i     (bus.phi_out),
        .b_i     (prev_q),
        .match_o (cmp_match)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phi_in_q    <= '0;
            prev_q      <= '0;
            result_q    <= '0;
            have_prev_q <= 1'b0;
            stable_q    <= '0;
            tick_q      <= '0;
            converged_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phi_in_q    <= phi_in_d;
            prev_q      <= prev_d;
            result_q    <= result_d;
            have_prev_q <= have_prev_d;
            stable_q    <= stable_d;
            tick_q      <= tick_d;
            converged_q <= converged_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phi_in_d    = phi_in_q;
        prev_d      = prev_q;
        result_d    = result_q;
        have_prev_d = have_prev_q;
        stable_d    = stable_q;
        tick_d      = tick_q;
        converged_d = converged_q;
        done_d      = 1'b0;
        full_tick   = 1'b0;
        // abort takes priority over a simultaneous start
        start_ok    = bus.start && !bus.abort;

        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d     = INIT;
                    cnt_d       = '0;
                    phi_in_d    = bus.pattern_in;
                    tick_d      = '0;
                    stable_d    = '0;
                    result_d    = '0;
                    converged_d = 1'b0;
                    have_prev_d = 1'b0;
                end
            end

            INIT: begin
                if (bus.abort) begin
                    state_d     = DONE;
                    converged_d = 1'b0;
                    done_d      = 1'b1;
                end else if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // cnt_q is the position in the tick period and keeps counting
            // through CHECK, so ticks stay exactly TICK_DIV clocks apart.
            RUN: begin
                if (bus.abort) begin
                    state_d     = DONE;
                    converged_d = 1'b0;
                    done_d      = 1'b1;
                end else if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
                    full_tick = 1'b1;
                    tick_d    = tick_q + 1'b1;
                    cnt_d     = '0;
                    state_d   = CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            CHECK: begin
                if (bus.abort) begin
                    state_d     = DONE;
                    converged_d = 1'b0;
                    done_d      = 1'b1;
                end else if (cnt_q == CNT_W'(SAMPLE_POS)) begin
                    result_d    = bus.phi_out;
                    prev_d      = bus.phi_out;
                    have_prev_d = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    // The first sample of a run has nothing to compare with.
                    if (have_prev_q && cmp_match) begin
                        stable_d = stable_q + 1'b1;
                    end else begin
                        stable_d = '0;
                    end
                    // Convergence is tested before timeout so it wins a tie.
                    if (stable_d == ST_W'(STABLE_TICKS)) begin
                        state_d     = DONE;
                        converged_d = 1'b1;
                        done_d      = 1'b1;
                    end else if (tick_q == TC_W'(MAX_TICKS)) begin
                        state_d     = DONE;
                        converged_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.phi_in     = phi_in_q;
    assign bus.net_init   = (state_q == IDLE) || (state_q == INIT);
    assign bus.full_tick  = full_tick;
    assign bus.busy       = (state_q == INIT) || (state_q == RUN) || (state_q == CHECK);
    assign bus.done       = done_q;
    assign bus.converged  = converged_q;
    assign bus.tick_count = tick_q;
    assign bus.result     = result_q;
    assign bus.state_dbg  = state_q;

endmodule
